// File: rtl/rra_grant_sequencer_if.sv
// Bus bundle for rra_grant_sequencer: APB-style register port plus request/grant lines.
// The master modport belongs to the bus/client side and the slave modport to the sequencer.
interface rra_grant_sequencer_if #(
  parameter int unsigned NUM_REQUESTS = 8,
  parameter int unsigned IDX_W        = $clog2(NUM_REQUESTS)
);
  logic                    PSel_i;
  logic                    PWrite_i;
  logic [7:0]              PAddr_i;
  logic [31:0]             PWData_i;
  logic [31:0]             PRData_o;
  logic [NUM_REQUESTS-1:0] req_i;
  logic [NUM_REQUESTS-1:0] done_i;
  logic [NUM_REQUESTS-1:0] gnt_o;
  logic [IDX_W-1:0]        gnt_idx_o;
  logic                    busy_o;

  modport master (
    output PSel_i,
    output PWrite_i,
    output PAddr_i,
    output PWData_i,
    output req_i,
    output done_i,
    input  PRData_o,
    input  gnt_o,
    input  gnt_idx_o,
    input  busy_o
  );

  modport slave (
    input  PSel_i,
    input  PWrite_i,
    input  PAddr_i,
    input  PWData_i,
    input  req_i,
    input  done_i,
    output PRData_o,
    output gnt_o,
    output gnt_idx_o,
    output busy_o
  );
endinterface

// File: rtl/rra_grant_sequencer.sv
// Round-robin grant sequencer with APB control/status registers.
// Each grant is held until done, request drop, disable or timeout, followed by a one-cycle gap.
module rra_grant_sequencer #(
  parameter int unsigned NUM_REQUESTS = 8,
  parameter int unsigned IDX_W        = $clog2(NUM_REQUESTS)
) (
  input logic                 Pclk_i,
  input logic                 PResetn_i,
  rra_grant_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_TOCLR  = 8'h08;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUESTS - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_REQUESTS);

  logic [1:0]              state;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        gnt_idx;
  logic [NUM_REQUESTS-1:0] gnt;
  logic                    busy;

  logic                    ctrl_en;
  logic [3:0]              ctrl_t;
  logic [3:0]              t_lat;
  logic [3:0]              tcnt;
  logic [7:0]              to_count;
  logic [31:0]             prdata;

  logic                    wr_en;
  logic                    rd_en;
  logic                    toclr_wr;
  logic [IDX_W-1:0]        sel;
  logic                    sel_valid;
  logic [IDX_W:0]          cand;
  logic [NUM_REQUESTS-1:0] sel_onehot;
  logic [IDX_W-1:0]        idx_next;
  logic                    rel_early;
  logic                    rel_timeout;
  logic                    release_now;
  logic                    arb_now;
  logic                    timeout_hit;
  logic [31:0]             rd_mux;

  assign wr_en    = bus.PSel_i & bus.PWrite_i;
  assign rd_en    = bus.PSel_i & ~bus.PWrite_i;
  assign toclr_wr = wr_en && (bus.PAddr_i == ADDR_TOCLR);

  // First set request at or above ptr, wrapping past the top requester.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQUESTS; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= NUM_EXT) begin
        cand = cand - NUM_EXT;
      end
      if (!sel_valid && bus.req_i[cand[IDX_W-1:0]]) begin
        sel_valid = 1'b1;
        sel       = cand[IDX_W-1:0];
      end
    end
  end

  assign sel_onehot = NUM_REQUESTS'(1) << sel;
  assign idx_next   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);

  assign rel_early   = bus.done_i[gnt_idx] | ~bus.req_i[gnt_idx] | ~ctrl_en;
  assign rel_timeout = (t_lat != 4'd0) && (tcnt == t_lat - 4'd1);
  assign release_now = (state == GRANT) && (rel_early || rel_timeout);
  assign timeout_hit = (state == GRANT) && rel_timeout && !rel_early;

  // The release cycle also arbitrates (ptr is already advanced on the exit
  // edge), so back-to-back grants see exactly one idle gnt cycle between them.
  assign arb_now = ((state == IDLE) || (state == RELEASE)) && ctrl_en && sel_valid;

  always_ff @(posedge Pclk_i or negedge PResetn_i) begin
    if (!PResetn_i) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      t_lat   <= '0;
      tcnt    <= '0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (arb_now) begin
            state   <= GRANT;
            gnt     <= sel_onehot;
            gnt_idx <= sel;
            busy    <= 1'b1;
            t_lat   <= ctrl_t;
            tcnt    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (release_now) begin
            state <= RELEASE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= idx_next;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Pclk_i or negedge PResetn_i) begin
    if (!PResetn_i) begin
      ctrl_en <= 1'b0;
      ctrl_t  <= '0;
    end else if (wr_en && (bus.PAddr_i == ADDR_CTRL)) begin
      ctrl_en <= bus.PWData_i[0];
      ctrl_t  <= bus.PWData_i[7:4];
    end
  end

  always_ff @(posedge Pclk_i or negedge PResetn_i) begin
    if (!PResetn_i) begin
      to_count <= '0;
    end else if (toclr_wr) begin
      to_count <= '0;
    end else if (timeout_hit && (to_count != 8'hFF)) begin
      to_count <= to_count + 8'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.PAddr_i)
      ADDR_CTRL: begin
        rd_mux[0]   = ctrl_en;
        rd_mux[7:4] = ctrl_t;
      end
      ADDR_STATUS: begin
        rd_mux[IDX_W-1:0] = gnt_idx;
        rd_mux[8]         = busy;
        rd_mux[23:16]     = to_count;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge Pclk_i or negedge PResetn_i) begin
    if (!PResetn_i) begin
      prdata <= '0;
    end else if (rd_en) begin
      prdata <= rd_mux;
    end
  end

  assign bus.PRData_o  = prdata;
  assign bus.gnt_o     = gnt;
  assign bus.gnt_idx_o = gnt_idx;
  assign bus.busy_o    = busy;

  a_gnt_onehot: assert property (@(posedge Pclk_i) disable iff (!PResetn_i) $onehot0(gnt));
  a_busy_match: assert property (@(posedge Pclk_i) disable iff (!PResetn_i) busy == (|gnt));

endmodule

// File: tb/tb_rra_grant_sequencer.sv
// Directed self-checking bench for rra_grant_sequencer: reset, rotation, timeout,
// done/timeout collision, fairness wrap, disable and asynchronous reset mid-grant.
module tb_rra_grant_sequencer;
  localparam int unsigned NUM_REQUESTS = 8;
  localparam int unsigned IDX_W        = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  rra_grant_sequencer_if #(.NUM_REQUESTS(NUM_REQUESTS), .IDX_W(IDX_W)) bus ();

  rra_grant_sequencer #(.NUM_REQUESTS(NUM_REQUESTS), .IDX_W(IDX_W)) dut (
    .Pclk_i   (clk),
    .PResetn_i(rst_n),
    .bus      (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    bus.PSel_i   = 1'b1;
    bus.PWrite_i = 1'b1;
    bus.PAddr_i  = addr;
    bus.PWData_i = data;
    tick();
    bus.PSel_i   = 1'b0;
    bus.PWrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
    bus.PSel_i   = 1'b1;
    bus.PWrite_i = 1'b0;
    bus.PAddr_i  = addr;
    tick();
    bus.PSel_i   = 1'b0;
    data         = bus.PRData_o;
  endtask

  initial begin
    bus.PSel_i   = 1'b0;
    bus.PWrite_i = 1'b0;
    bus.PAddr_i  = '0;
    bus.PWData_i = '0;
    bus.req_i    = 8'hFF;
    bus.done_i   = '0;

    // Reset and disabled
    repeat (2) tick();
    check("rst_gnt", 32'(bus.gnt_o), 32'h0);
    check("rst_idx", 32'(bus.gnt_idx_o), 32'h0);
    check("rst_busy", 32'(bus.busy_o), 32'h0);
    check("rst_prdata", bus.PRData_o, 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("dis_gnt", 32'(bus.gnt_o), 32'h0);
    check("dis_busy", 32'(bus.busy_o), 32'h0);
    apb_read(8'h00, rdata);
    check("dis_ctrl_rd", rdata, 32'h0);
    apb_read(8'h04, rdata);
    check("dis_status_rd", rdata, 32'h0);

    // Round-robin rotation, done pulsed in every grant cycle
    bus.req_i = '0;
    tick();
    apb_write(8'h00, 32'h01);
    bus.req_i = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      check("rr_gnt", 32'(bus.gnt_o), 32'h1 << (k % 8));
      bus.done_i = '1;
      tick();
      check("rr_gap", 32'(bus.gnt_o), 32'h0);
      bus.done_i = '0;
      if (k == 8) bus.req_i = '0;
      tick();
    end
    check("rr_idle", 32'(bus.gnt_o), 32'h0);

    // Timeout T=3; STATUS read in each gap, TOCLR lands on the 4th timeout edge
    apb_write(8'h00, 32'h31);
    bus.req_i = 8'h04;
    tick();
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 3; c++) begin
        check("to_gnt", 32'(bus.gnt_o), 32'h04);
        if (c == 0 && g > 0) begin
          bus.PSel_i = 1'b0;
          check("to_count", bus.PRData_o, (32'(g) << 16) | 32'h2);
        end
        if (g == 3 && c == 2) begin
          bus.PSel_i   = 1'b1;
          bus.PWrite_i = 1'b1;
          bus.PAddr_i  = 8'h08;
          bus.PWData_i = 32'hDEAD_BEEF;
        end
        tick();
      end
      check("to_gap", 32'(bus.gnt_o), 32'h0);
      bus.PSel_i   = 1'b1;
      bus.PWrite_i = 1'b0;
      bus.PAddr_i  = 8'h04;
      tick();
    end
    check("to_gnt5", 32'(bus.gnt_o), 32'h04);
    bus.PSel_i = 1'b0;
    check("toclr_race", bus.PRData_o, 32'h0000_0002);
    bus.req_i = '0;
    tick();
    check("to_drop", 32'(bus.gnt_o), 32'h0);
    tick();

    // T=2: one pure timeout, then done in the 2nd cycle collides with timeout
    apb_write(8'h00, 32'h21);
    bus.req_i = 8'h04;
    tick();
    check("t2_c1", 32'(bus.gnt_o), 32'h04);
    tick();
    check("t2_c2", 32'(bus.gnt_o), 32'h04);
    tick();
    check("t2_gap", 32'(bus.gnt_o), 32'h0);
    tick();
    check("col_c1", 32'(bus.gnt_o), 32'h04);
    tick();
    check("col_c2", 32'(bus.gnt_o), 32'h04);
    bus.done_i = 8'h04;
    tick();
    check("col_rel", 32'(bus.gnt_o), 32'h0);
    bus.done_i = '0;
    bus.req_i  = '0;
    tick();
    apb_read(8'h04, rdata);
    check("col_count", rdata, 32'h0001_0002);

    // Fairness and pointer wrap
    apb_write(8'h00, 32'h01);
    bus.req_i = 8'h80;
    tick();
    check("fair_g7", 32'(bus.gnt_o), 32'h80);
    bus.req_i  = 8'h81;
    bus.done_i = 8'h80;
    tick();
    check("fair_gap", 32'(bus.gnt_o), 32'h0);
    bus.done_i = '0;
    tick();
    check("fair_gnt", 32'(bus.gnt_o), 32'h01);
    check("fair_idx", 32'(bus.gnt_idx_o), 32'h0);
    apb_read(8'h04, rdata);
    check("fair_status", rdata, 32'h0001_0100);
    check("fair_hold", 32'(bus.gnt_o), 32'h01);

    // Clear enable mid-grant
    apb_write(8'h00, 32'h00);
    check("en_hold", 32'(bus.gnt_o), 32'h01);
    tick();
    check("en_drop", 32'(bus.gnt_o), 32'h0);
    tick();
    check("en_idle", 32'(bus.gnt_o), 32'h0);
    check("en_idx_keep", 32'(bus.gnt_idx_o), 32'h0);
    check("en_busy", 32'(bus.busy_o), 32'h0);

    // Asynchronous reset mid-grant
    apb_write(8'h00, 32'h01);
    tick();
    check("pre_rst", 32'(bus.gnt_o), 32'h80);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_gnt", 32'(bus.gnt_o), 32'h0);
    check("rst_async_busy", 32'(bus.busy_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apb_write(8'h00, 32'h01);
    tick();
    check("rst_ptr_gnt", 32'(bus.gnt_o), 32'h01);
    check("rst_ptr_idx", 32'(bus.gnt_idx_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
